tff_down_counter: RTL and testbench

Loadable, synchronous modulo down-counter (countdown timer) built from toggle-cell flip-flops. It is the counterpart of the toggle-based up-counting chain: it counts down from a loaded value and flags expiry. The `tc` pulse can drive other blocks. It sits beside the latch/flip-flop primitives and is the first timing source for downstream control logic.

---
 rtl/tff_down_counter_pkg.sv | 17 +
 rtl/tff_down_counter_if.sv | 15 +
 rtl/tff_load_cell.sv | 17 +
 rtl/tff_down_counter.sv | 76 +++++++
 tb/tb_tff_down_counter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/tff_down_counter_pkg.sv
// Shared types and limits for the toggle-cell down-counter.
// State encoding plus the WIDTH legality check used at elaboration.
package tff_down_counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/tff_down_counter_if.sv
// Control/status bundle for tff_down_counter; clk and clear stay plain ports.
interface tff_down_counter_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] D;
  logic             en;
  logic             auto;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;

  modport master (output load, D, en, auto, input  Q, tc, busy);
  modport slave  (input  load, D, en, auto, output Q, tc, busy);
endinterface

// File: rtl/tff_load_cell.sv
// One T flip-flop with synchronous clear and a parallel-load mux.
module tff_load_cell (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic d,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (clear)     q <= 1'b0;
    else if (load) q <= d;
    else           q <= q ^ t;
  end

endmodule

// File: rtl/tff_down_counter.sv
// Loadable modulo down-counter built from toggle cells; flags expiry with a
// registered tc pulse and optionally reloads from R.
module tff_down_counter
  import tff_down_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               clear,
  tff_down_counter_if.slave  bus
);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("tff_down_counter: WIDTH must be in 2..16");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, r, d_sel, tgl, zero_pfx;
  logic             run, cnt_en, expiry, reload, cell_load;
  logic             tc_q, tc_nxt;

  assign run       = (state == ST_RUN);
  assign cnt_en    = run & bus.en;
  assign expiry    = cnt_en & (q == WIDTH'(1));
  assign reload    = expiry & bus.auto;
  // Auto-reload reuses the cells' parallel-load path with R as the source.
  assign cell_load = bus.load | reload;
  assign d_sel     = bus.load ? bus.D : r;

  // Bit i toggles when every lower bit is zero (borrow ripple).
  assign zero_pfx[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_pfx
    assign zero_pfx[i] = zero_pfx[i-1] & ~q[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign tgl[i] = cnt_en & zero_pfx[i];
    tff_load_cell u_cell (
      .clk   (clk),
      .clear (clear),
      .load  (cell_load),
      .d     (d_sel[i]),
      .t     (tgl[i]),
      .q     (q[i])
    );
  end

  // Load outranks expiry, so a load on the expiry cycle cancels tc.
  always_comb begin
    state_nxt = state;
    tc_nxt    = 1'b0;
    if (bus.load) begin
      state_nxt = (bus.D != '0) ? ST_RUN : ST_IDLE;
    end else if (expiry) begin
      tc_nxt = 1'b1;
      if (!bus.auto) state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_IDLE;
      tc_q  <= 1'b0;
      r     <= '0;
    end else begin
      state <= state_nxt;
      tc_q  <= tc_nxt;
      if (bus.load) r <= bus.D;
    end
  end

  assign bus.Q    = q;
  assign bus.tc   = tc_q;
  assign bus.busy = run;

endmodule

// File: tb/tb_tff_down_counter.sv
// Directed bench for tff_down_counter (WIDTH=4) with hand-computed vectors.
module tb_tff_down_counter;

  logic clk = 1'b0;
  logic clear;
  int   n_cmp = 0;
  int   n_err = 0;

  tff_down_counter_if #(.WIDTH(4)) bus ();

  tff_down_counter #(.WIDTH(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [3:0] d, input logic e, input logic a);
    bus.load = ld; bus.D = d; bus.en = e; bus.auto = a;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    step(); step();
    n_cmp++;
    if ({bus.Q, bus.tc, bus.busy} !== 6'b0000_0_0) begin
      n_err++;
      $display("FAIL reset: Q/tc/busy got %0d/%b/%b want 0/0/0", bus.Q, bus.tc, bus.busy);
    end
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({bus.Q, bus.tc, bus.busy} !== 6'b0000_0_0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: Q/tc/busy got %0d/%b/%b want 0/0/0", i, bus.Q, bus.tc, bus.busy);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] eq [6] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    logic       et [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       eb [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    drive(1'b1, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      bus.load = 1'b0;
      n_cmp++;
      if ({bus.Q, bus.tc, bus.busy} !== {eq[i], et[i], eb[i]}) begin
        n_err++;
        $display("FAIL one_shot[%0d]: Q/tc/busy got %0d/%b/%b want %0d/%b/%b",
                 i, bus.Q, bus.tc, bus.busy, eq[i], et[i], eb[i]);
      end
    end
    step();
    n_cmp++;
    if ({bus.Q, bus.tc, bus.busy} !== 6'b0000_0_0) begin
      n_err++;
      $display("FAIL one_shot_after: Q/tc/busy got %0d/%b/%b want 0/0/0", bus.Q, bus.tc, bus.busy);
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0] eq [11] = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};
    logic       et [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 4'd3, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step();
      bus.load = 1'b0;
      n_cmp++;
      if ({bus.Q, bus.tc, bus.busy} !== {eq[i], et[i], 1'b1}) begin
        n_err++;
        $display("FAIL auto_reload[%0d]: Q/tc/busy got %0d/%b/%b want %0d/%b/1",
                 i, bus.Q, bus.tc, bus.busy, eq[i], et[i]);
      end
    end
  endtask

  task automatic test_gated_enable();
    logic       en_seq [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] eq     [7] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0};
    logic       et     [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       eb     [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    drive(1'b1, 4'd4, 1'b0, 1'b0);
    step();
    bus.load = 1'b0;
    n_cmp++;
    if ({bus.Q, bus.tc, bus.busy} !== 6'b0100_0_1) begin
      n_err++;
      $display("FAIL gated_load: Q/tc/busy got %0d/%b/%b want 4/0/1", bus.Q, bus.tc, bus.busy);
    end
    for (int i = 0; i < 7; i++) begin
      bus.en = en_seq[i];
      step();
      n_cmp++;
      if ({bus.Q, bus.tc, bus.busy} !== {eq[i], et[i], eb[i]}) begin
        n_err++;
        $display("FAIL gated[%0d]: Q/tc/busy got %0d/%b/%b want %0d/%b/%b",
                 i, bus.Q, bus.tc, bus.busy, eq[i], et[i], eb[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    // Load on the expiry cycle: load wins, no tc.
    drive(1'b1, 4'd2, 1'b1, 1'b0);
    step();
    bus.load = 1'b0;
    step();
    drive(1'b1, 4'd9, 1'b1, 1'b0);
    step();
    n_cmp++;
    if ({bus.Q, bus.tc, bus.busy} !== 6'b1001_0_1) begin
      n_err++;
      $display("FAIL load_at_expiry: Q/tc/busy got %0d/%b/%b want 9/0/1", bus.Q, bus.tc, bus.busy);
    end
    bus.load = 1'b0;
    step();
    n_cmp++;
    if (bus.Q !== 4'd8) begin
      n_err++;
      $display("FAIL reload_run: Q got %0d want 8", bus.Q);
    end
    // Clear together with load at Q==1: clear wins, tc suppressed.
    drive(1'b1, 4'd1, 1'b1, 1'b0);
    step();
    clear = 1'b1;
    drive(1'b1, 4'd7, 1'b1, 1'b0);
    step();
    clear = 1'b0;
    bus.load = 1'b0;
    n_cmp++;
    if ({bus.Q, bus.tc, bus.busy} !== 6'b0000_0_0) begin
      n_err++;
      $display("FAIL clear_vs_load: Q/tc/busy got %0d/%b/%b want 0/0/0", bus.Q, bus.tc, bus.busy);
    end
    // Period 1 in auto mode: tc held high on every enabled cycle.
    drive(1'b1, 4'd1, 1'b1, 1'b1);
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({bus.Q, bus.tc, bus.busy} !== 6'b0001_1_1) begin
        n_err++;
        $display("FAIL period1[%0d]: Q/tc/busy got %0d/%b/%b want 1/1/1", i, bus.Q, bus.tc, bus.busy);
      end
    end
  endtask

  task automatic test_edge_values();
    drive(1'b1, 4'd0, 1'b1, 1'b0);
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({bus.Q, bus.tc, bus.busy} !== 6'b0000_0_0) begin
        n_err++;
        $display("FAIL load_zero[%0d]: Q/tc/busy got %0d/%b/%b want 0/0/0", i, bus.Q, bus.tc, bus.busy);
      end
    end
    drive(1'b1, 4'd15, 1'b1, 1'b0);
    step();
    bus.load = 1'b0;
    n_cmp++;
    if ({bus.Q, bus.busy} !== 5'b1111_1) begin
      n_err++;
      $display("FAIL load_15: Q/busy got %0d/%b want 15/1", bus.Q, bus.busy);
    end
    for (int i = 1; i <= 15; i++) begin
      logic [3:0] eq;
      logic       et;
      eq = 4'(15 - i);
      et = (i == 15);
      step();
      n_cmp++;
      if ({bus.Q, bus.tc, bus.busy} !== {eq, et, ~et}) begin
        n_err++;
        $display("FAIL count15[%0d]: Q/tc/busy got %0d/%b/%b want %0d/%b/%b",
                 i, bus.Q, bus.tc, bus.busy, eq, et, ~et);
      end
    end
  endtask

  initial begin
    clear = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_gated_enable();
    test_simultaneous();
    test_edge_values();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
